fifo_rr_arbiter: RTL

Round-robin read scheduler sharing one downstream consumer between N_SRC first-word-fall-through FIFOs (`dout` valid while not empty, `re` pops on the clock edge). It picks one non-empty source per cycle, pops it, and registers the word plus its source index into a single output stage with a valid/ready handshake. A per-source burst limit lets a source hold the grant for up to BURST consecutive words before the grant rotates. Target use: merging per-requester FIFOs into a shared bus master or memory port.

---
 rtl/fifo_rr_arbiter_if.sv | 28 ++
 rtl/fifo_rr_arbiter.sv | 92 +++++++++
 2 files changed

// File: rtl/fifo_rr_arbiter_if.sv
// Source-side and consumer-side signals of the round-robin FIFO read scheduler.
// master: the scheduler (drives pop strobes and the output stage).
// slave: the environment (source FIFOs, enable, consumer ready).
interface fifo_rr_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int N_SRC = 4
);
  localparam int IDW = $clog2(N_SRC);

  logic                   enable_i;     // 1 = pops allowed
  logic [N_SRC-1:0]       src_empty_i;  // per-source empty flag
  logic [N_SRC*WIDTH-1:0] src_data_i;   // per-source FWFT head word
  logic [N_SRC-1:0]       src_re_o;     // per-source pop strobe, one-hot or zero
  logic                   valid_o;      // output stage holds a word
  logic [WIDTH-1:0]       data_o;       // registered word
  logic [IDW-1:0]         src_id_o;     // source index of data_o
  logic                   ready_i;      // consumer accepts data_o

  modport master (
    input  enable_i, src_empty_i, src_data_i, ready_i,
    output src_re_o, valid_o, data_o, src_id_o
  );

  modport slave (
    output enable_i, src_empty_i, src_data_i, ready_i,
    input  src_re_o, valid_o, data_o, src_id_o
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin read scheduler merging N_SRC FWFT FIFOs into one registered valid/ready output stage.
// Latency: source head to data_o in 1 cycle; 1 word/cycle sustained, no bubble on grant rotation.
// Backpressure: valid_o && !ready_i blocks all pops and freezes state; enable_i=0 stops pops but drains.
// Ports: clk_i, rstn_i (async active-low); bus (master modport) carries enable, source flags/data/pops,
//        and the output stage valid/data/src_id with ready.
module fifo_rr_arbiter #(
  parameter int WIDTH = 32,
  parameter int N_SRC = 4,
  parameter int BURST = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  fifo_rr_arbiter_if.master    bus
);
  localparam int IDW = $clog2(N_SRC);
  localparam int CW  = $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   cur_q;
  logic [CW-1:0]    cnt_q;

  logic             load;
  logic             any;
  logic             pop;
  logic             keep;
  logic             found;
  logic [IDW-1:0]   scan_pick;
  logic [IDW-1:0]   pick;
  logic [WIDTH-1:0] pick_dat;
  int               idx;

  assign load = !valid_q || bus.ready_i;
  assign any  = |(~bus.src_empty_i);
  // Gating with rstn_i suppresses a strobe in the reset cycle, since the pop would be lost.
  assign pop  = load && bus.enable_i && any && rstn_i;

  // Scan starts one past the owner and ends at the owner itself, so a lone
  // non-empty source is re-granted after its burst with a fresh count.
  always_comb begin
    scan_pick = cur_q;
    found     = 1'b0;
    idx       = 0;
    for (int off = 1; off <= N_SRC; off++) begin
      idx = int'(cur_q) + off;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!found && !bus.src_empty_i[IDW'(idx)]) begin
        scan_pick = IDW'(idx);
        found     = 1'b1;
      end
    end
    keep = !bus.src_empty_i[cur_q] && (cnt_q < BURST_C);
    pick = keep ? cur_q : scan_pick;
  end

  // Explicit muxes keep src_re_o free of any path from src_data_i.
  always_comb begin
    pick_dat = '0;
    for (int k = 0; k < N_SRC; k++) begin
      bus.src_re_o[k] = pop && (pick == IDW'(k));
      if (pick == IDW'(k)) pick_dat = bus.src_data_i[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
    end else if (pop) begin
      valid_q <= 1'b1;
      data_q  <= pick_dat;
      id_q    <= pick;
      if (pick == cur_q && cnt_q < BURST_C) begin
        cnt_q <= cnt_q + CW'(1);
      end else begin
        cur_q <= pick;
        cnt_q <= CW'(1);
      end
    end else if (load) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.valid_o  = valid_q;
  assign bus.data_o   = data_q;
  assign bus.src_id_o = id_q;
endmodule
